axil_reg_slave: RTL



---
 rtl/axil_reg_slave.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axil_reg_slave.sv
// AXI-Lite slave register bank: NUM_REGS full-word registers behind independent
// AW/W holding slots, one B per write, one R per read, all contents exported.
module axil_reg_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic                           AWVALID,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  output logic                           AWREADY,
  input  logic                           WVALID,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  output logic                           WREADY,
  output logic                           BVALID,
  output logic [1:0]                     BRESP,
  input  logic                           BREADY,
  input  logic                           ARVALID,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  output logic                           ARREADY,
  output logic                           RVALID,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int                  IDX_W       = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] SPAN        = (ADDR_WIDTH+1)'(NUM_REGS*4);
  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;
  localparam logic [1:0]          RESP_DECERR = 2'b11;

  // Range is checked before alignment, so an unaligned out-of-range access is DECERR.
  function automatic logic [1:0] decodeResp(input logic [ADDR_WIDTH-1:0] off);
    if ({1'b0, off} >= SPAN)    decodeResp = RESP_DECERR;
    else if (off[1:0] != 2'b00) decodeResp = RESP_SLVERR;
    else                        decodeResp = RESP_OKAY;
  endfunction

  logic                           ready_q;
  logic                           awFull_q, awFull_d;
  logic [ADDR_WIDTH-1:0]          awAddr_q, awAddr_d;
  logic                           wFull_q, wFull_d;
  logic [DATA_WIDTH-1:0]          wData_q, wData_d;
  logic                           bValid_q, bValid_d;
  logic [1:0]                     bResp_q, bResp_d;
  logic                           rValid_q, rValid_d;
  logic [DATA_WIDTH-1:0]          rData_q, rData_d;
  logic [1:0]                     rResp_q, rResp_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;

  logic [ADDR_WIDTH-1:0] awOff, arOff;
  logic [IDX_W-1:0]      awIdx, arIdx;
  logic [1:0]            awResp, arResp;
  logic                  awHs, wHs, arHs, bHs, rHs, commit;

  // ready_q keeps every ready low until one edge after reset is released.
  assign AWREADY = ready_q & ARESETN & ~awFull_q;
  assign WREADY  = ready_q & ARESETN & ~wFull_q;
  assign ARREADY = ready_q & ARESETN & ~rValid_q;

  assign awHs   = AWVALID & AWREADY;
  assign wHs    = WVALID & WREADY;
  assign arHs   = ARVALID & ARREADY;
  assign bHs    = bValid_q & BREADY;
  assign rHs    = rValid_q & RREADY;
  assign commit = awFull_q & wFull_q & ~bValid_q;

  assign awOff  = awAddr_q - BASE_ADDR;
  assign arOff  = ARADDR - BASE_ADDR;
  assign awIdx  = awOff[IDX_W+1:2];
  assign arIdx  = arOff[IDX_W+1:2];
  assign awResp = decodeResp(awOff);
  assign arResp = decodeResp(arOff);

  always_comb begin
    awFull_d = awFull_q;
    awAddr_d = awAddr_q;
    wFull_d  = wFull_q;
    wData_d  = wData_q;
    bValid_d = bValid_q;
    bResp_d  = bResp_q;
    rValid_d = rValid_q;
    rData_d  = rData_q;
    rResp_d  = rResp_q;
    regs_d   = regs_q;

    if (awHs) begin
      awFull_d = 1'b1;
      awAddr_d = AWADDR;
    end
    if (wHs) begin
      wFull_d = 1'b1;
      wData_d = WDATA;
    end

    if (bHs) bValid_d = 1'b0;
    // A commit needs both slots full, so it never coincides with a slot handshake.
    if (commit) begin
      awFull_d = 1'b0;
      wFull_d  = 1'b0;
      bValid_d = 1'b1;
      bResp_d  = awResp;
      if (awResp == RESP_OKAY) regs_d[int'(awIdx)*DATA_WIDTH +: DATA_WIDTH] = wData_q;
    end

    if (rHs) rValid_d = 1'b0;
    // Reads sample regs_q, so a same-edge commit returns the pre-write value.
    if (arHs) begin
      rValid_d = 1'b1;
      rResp_d  = arResp;
      rData_d  = (arResp == RESP_OKAY) ? regs_q[int'(arIdx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ready_q  <= 1'b0;
      awFull_q <= 1'b0;
      awAddr_q <= '0;
      wFull_q  <= 1'b0;
      wData_q  <= '0;
      bValid_q <= 1'b0;
      bResp_q  <= 2'b00;
      rValid_q <= 1'b0;
      rData_q  <= '0;
      rResp_q  <= 2'b00;
      regs_q   <= '0;
    end else begin
      ready_q  <= 1'b1;
      awFull_q <= awFull_d;
      awAddr_q <= awAddr_d;
      wFull_q  <= wFull_d;
      wData_q  <= wData_d;
      bValid_q <= bValid_d;
      bResp_q  <= bResp_d;
      rValid_q <= rValid_d;
      rData_q  <= rData_d;
      rResp_q  <= rResp_d;
      regs_q   <= regs_d;
    end
  end

  assign BVALID = bValid_q;
  assign BRESP  = bResp_q;
  assign RVALID = rValid_q;
  assign RDATA  = rData_q;
  assign RRESP  = rResp_q;
  assign regs_o = regs_q;

endmodule
